chan_mux_scan: RTL and testbench

CHAN_MUX_SCAN -- requirements
Module: chan_mux_scan

---
 rtl/chan_mux_scan.sv | 121 ++++++++++++
 tb/tb_chan_mux_scan.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/chan_mux_scan.sv
// rtl/chan_mux_scan.sv - N-channel data mux with fixed-select or round-robin scan into a one-beat output register
module chan_mux_scan #(
   parameter  int N_CH = 16,
   parameter  int DW   = 4,
   localparam int SW   = $clog2(N_CH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               mode,
   input  logic [SW-1:0]      sel,
   input  logic [N_CH-1:0]    ch_en,
   input  logic [N_CH*DW-1:0] in_data,
   input  logic [N_CH-1:0]    in_valid,
   output logic [N_CH-1:0]    in_ready,
   output logic [DW-1:0]      out_data,
   output logic [SW-1:0]      out_ch,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               sel_err
);

   logic [SW-1:0]   r_ptr;
   logic [DW-1:0]   r_out_data;
   logic [SW-1:0]   r_out_ch;
   logic            r_out_valid;
   logic            r_sel_err;

   logic [N_CH-1:0] w_eligible;
   logic            w_slot_free;
   logic            w_sel_bad;
   logic            w_fix_hit;
   logic            w_scan_hit;
   logic            w_grant_vld;
   logic [SW-1:0]   w_scan_idx;
   logic [SW-1:0]   w_grant_idx;
   logic [SW-1:0]   w_ptr_next;
   logic [DW-1:0]   w_grant_data;

   assign w_eligible  = in_valid & ch_en;
   assign w_slot_free = !r_out_valid || out_ready;

   // Only a non-power-of-two channel count leaves select codes without a channel.
   if ((1 << SW) == N_CH) begin : g_sel_full
      assign w_sel_bad = 1'b0;
   end else begin : g_sel_sparse
      assign w_sel_bad = (sel > SW'(N_CH - 1));
   end

   always_comb begin
      w_fix_hit = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if ((sel == SW'(i)) && w_eligible[i]) begin
            w_fix_hit = 1'b1;
         end
      end
   end

   // Walk offsets from far to near so the channel closest to ptr wins.
   always_comb begin
      int            j;
      logic [SW-1:0] idx;
      w_scan_hit = 1'b0;
      w_scan_idx = '0;
      j          = 0;
      idx        = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         j = int'(r_ptr) + k;
         if (j >= N_CH) begin
            j = j - N_CH;
         end
         idx = SW'(j);
         if (w_eligible[idx]) begin
            w_scan_hit = 1'b1;
            w_scan_idx = idx;
         end
      end
   end

   assign w_grant_idx = mode ? w_scan_idx : sel;
   assign w_grant_vld = rst_n && w_slot_free && (mode ? w_scan_hit : w_fix_hit);
   assign w_ptr_next  = (w_grant_idx == SW'(N_CH - 1)) ? '0 : w_grant_idx + SW'(1);

   always_comb begin
      w_grant_data = '0;
      in_ready     = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (w_grant_idx == SW'(i)) begin
            w_grant_data = in_data[i*DW +: DW];
            in_ready[i]  = w_grant_vld;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr       <= '0;
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_out_valid <= 1'b0;
         r_sel_err   <= 1'b0;
      end else begin
         r_sel_err <= !mode && w_sel_bad;
         if (w_grant_vld) begin
            r_out_data  <= w_grant_data;
            r_out_ch    <= w_grant_idx;
            r_out_valid <= 1'b1;
            if (mode) begin
               r_ptr <= w_ptr_next;
            end
         end else if (w_slot_free) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_ch    = r_out_ch;
   assign out_valid = r_out_valid;
   assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_chan_mux_scan.sv
// tb/tb_chan_mux_scan.sv - directed bench for chan_mux_scan (16-channel and 10-channel instances)
module tb_chan_mux_scan;

   logic        clk;
   logic        rst_n;

   logic        mode;
   logic [3:0]  sel;
   logic [15:0] ch_en;
   logic [63:0] in_data;
   logic [15:0] in_valid;
   logic [15:0] in_ready;
   logic [3:0]  out_data;
   logic [3:0]  out_ch;
   logic        out_valid;
   logic        out_ready;
   logic        sel_err;

   logic        b_mode;
   logic [3:0]  b_sel;
   logic [9:0]  b_ch_en;
   logic [39:0] b_in_data;
   logic [9:0]  b_in_valid;
   logic [9:0]  b_in_ready;
   logic [3:0]  b_out_data;
   logic [3:0]  b_out_ch;
   logic        b_out_valid;
   logic        b_out_ready;
   logic        b_sel_err;

   int          n_vec;
   int          n_err;
   logic [15:0] exp16;

   chan_mux_scan #(.N_CH(16), .DW(4)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .ch_en(ch_en),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
      .out_ready(out_ready), .sel_err(sel_err)
   );

   chan_mux_scan #(.N_CH(10), .DW(4)) u_dut10 (
      .clk(clk), .rst_n(rst_n), .mode(b_mode), .sel(b_sel), .ch_en(b_ch_en),
      .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .out_data(b_out_data), .out_ch(b_out_ch), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .sel_err(b_sel_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   task automatic load_pattern();
      for (int i = 0; i < 16; i++) in_data[i*4 +: 4] = 4'(i);
      for (int i = 0; i < 10; i++) b_in_data[i*4 +: 4] = 4'(i);
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      mode = 1'b1; sel = 4'd0; ch_en = 16'hFFFF; in_valid = 16'hFFFF; out_ready = 1'b1;
      b_mode = 1'b0; b_sel = 4'd0; b_ch_en = 10'h3FF; b_in_valid = 10'h000; b_out_ready = 1'b1;
      load_pattern();
      #2 rst_n = 1'b0;
      #1;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b expected 0", out_valid); end
      n_vec++;
      if (out_data !== 4'h0) begin n_err++; $display("FAIL rst_out_data: got %0h expected 0", out_data); end
      n_vec++;
      if (out_ch !== 4'h0) begin n_err++; $display("FAIL rst_out_ch: got %0h expected 0", out_ch); end
      n_vec++;
      if (sel_err !== 1'b0) begin n_err++; $display("FAIL rst_sel_err: got %0b expected 0", sel_err); end
      n_vec++;
      if (in_ready !== 16'h0000) begin n_err++; $display("FAIL rst_in_ready: got %0h expected 0", in_ready); end
      n_vec++;
      repeat (2) @(posedge clk);
      #2;
      if (in_ready !== 16'h0000) begin n_err++; $display("FAIL rst_in_ready_clk: got %0h expected 0", in_ready); end
      n_vec++;
      in_valid = 16'h0000; mode = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_idle_valid: got %0b expected 0", out_valid); end
      n_vec++;
   endtask

   task automatic test_fixed();
      mode = 1'b0; sel = 4'd5; ch_en = 16'hFFFF; in_valid = 16'h0020; out_ready = 1'b1;
      in_data[20 +: 4] = 4'hA;
      #1;
      if (in_ready !== 16'h0020) begin n_err++; $display("FAIL fix_in_ready: got %0h expected 0020", in_ready); end
      n_vec++;
      tick();
      if (out_data !== 4'hA) begin n_err++; $display("FAIL fix_out_data: got %0h expected a", out_data); end
      n_vec++;
      if (out_ch !== 4'd5) begin n_err++; $display("FAIL fix_out_ch: got %0d expected 5", out_ch); end
      n_vec++;
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL fix_out_valid: got %0b expected 1", out_valid); end
      n_vec++;
      in_valid = 16'h0000;
      tick();
      if ({out_valid, out_ch, out_data} !== {1'b0, 4'd5, 4'hA}) begin
         n_err++; $display("FAIL fix_idle_hold: got v=%0b ch=%0d d=%0h expected v=0 ch=5 d=a", out_valid, out_ch, out_data);
      end
      n_vec++;
      ch_en = 16'hFFDF; in_valid = 16'h0020;
      #1;
      if (in_ready !== 16'h0000) begin n_err++; $display("FAIL fix_disabled: got %0h expected 0", in_ready); end
      n_vec++;
      tick();
      in_valid = 16'h0000; ch_en = 16'hFFFF;
      load_pattern();
   endtask

   task automatic test_scan();
      mode = 1'b1; in_valid = 16'hFFFF; ch_en = 16'hFFFF; out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         exp16 = 16'h0001 << (c % 16);
         #1;
         check("scan_in_ready", 32'(in_ready), 32'(exp16));
         tick();
         check("scan_out_ch", 32'(out_ch), 32'(c % 16));
         check("scan_out_data", 32'(out_data), 32'(c % 16));
         check("scan_out_valid", 32'(out_valid), 32'd1);
      end
   endtask

   task automatic test_disabled();
      in_valid = 16'h1008; ch_en = 16'hEFFF;
      for (int c = 0; c < 4; c++) begin
         #1;
         check("dis_in_ready", 32'(in_ready), 32'h0008);
         tick();
         check("dis_out_ch", 32'(out_ch), 32'd3);
      end
   endtask

   task automatic test_stall();
      in_valid = 16'hFFFF; ch_en = 16'hFFFF; out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("stall_in_ready", 32'(in_ready), 32'h0);
         tick();
         check("stall_out", 32'({out_valid, out_ch, out_data}), 32'({1'b1, 4'd3, 4'd3}));
      end
      out_ready = 1'b1;
      #1;
      check("unstall_in_ready", 32'(in_ready), 32'h0010);
      tick();
      check("unstall_out", 32'({out_valid, out_ch, out_data}), 32'({1'b1, 4'd4, 4'd4}));
   endtask

   task automatic test_back_to_back();
      mode = 1'b0; sel = 4'd7;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("b2b_fix_ready", 32'(in_ready), 32'h0080);
         tick();
         check("b2b_fix_out", 32'({out_valid, out_ch}), 32'({1'b1, 4'd7}));
      end
      mode = 1'b1;
      #1;
      check("mode_sw_ready", 32'(in_ready), 32'h0020);
      tick();
      check("mode_sw_out_ch", 32'(out_ch), 32'd5);
      #1;
      check("mode_sw_next_ready", 32'(in_ready), 32'h0040);
      tick();
      check("mode_sw_next_ch", 32'(out_ch), 32'd6);
   endtask

   task automatic test_sel_err();
      b_mode = 1'b0; b_sel = 4'd12; b_in_valid = 10'h3FF; b_ch_en = 10'h3FF; b_out_ready = 1'b1;
      #1;
      check("selerr_in_ready", 32'(b_in_ready), 32'h0);
      tick();
      check("selerr_pulse", 32'(b_sel_err), 32'd1);
      check("selerr_out_valid", 32'(b_out_valid), 32'd0);
      tick();
      check("selerr_held", 32'(b_sel_err), 32'd1);
      b_sel = 4'd9;
      #1;
      check("sel9_in_ready", 32'(b_in_ready), 32'h200);
      tick();
      check("sel9_sel_err", 32'(b_sel_err), 32'd0);
      check("sel9_out", 32'({b_out_valid, b_out_ch, b_out_data}), 32'({1'b1, 4'd9, 4'd9}));
   endtask

   task automatic test_reset_stall();
      mode = 1'b1; in_valid = 16'hFFFF; ch_en = 16'hFFFF; out_ready = 1'b0;
      tick();
      check("rs_pre_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rs_out", 32'({out_valid, out_ch, out_data, sel_err}), 32'h0);
      check("rs_in_ready", 32'(in_ready), 32'h0);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      check("rs_restart_ready", 32'(in_ready), 32'h0001);
      tick();
      check("rs_restart_out", 32'({out_valid, out_ch}), 32'({1'b1, 4'd0}));
      tick();
      check("rs_restart_next", 32'({out_valid, out_ch, out_data}), 32'({1'b1, 4'd1, 4'd1}));
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      exp16 = '0;
      in_data = '0;
      b_in_data = '0;
      test_reset();
      test_fixed();
      test_scan();
      test_disabled();
      test_stall();
      test_back_to_back();
      test_sel_err();
      test_reset_stall();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
